// File: rtl/uart_tx_frame_pkg.sv
// Shared UART framing definitions: FSM state encodings, parity modes and the
// parity helper. The receive framer reuses these so both ends agree.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } frame_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Data narrower than 8 bits is zero-extended by the caller, which leaves the
  // XOR reduction unchanged.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// UART transmit framer: takes one word over valid/ready, then shifts start,
// data (LSB first), optional parity and stop bits onto txd, moving one bit per
// baud_pulse. baud_en keeps the external pulse generator running for the frame.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 baud_pulse,
  output logic                 baud_en,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_tx_frame: illegal DATA_BITS/PARITY/STOP_BITS combination");
  end

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  frame_state_t         state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 txd_d, ready_d, baud_en_d, busy_d, done_d;
  logic                 pulse_ok;

  // A pulse only counts while the generator is enabled, so strays in IDLE are dropped.
  assign pulse_ok = baud_pulse & baud_en;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd;
    ready_d    = tx_ready;
    baud_en_d  = baud_en;
    busy_d     = tx_busy;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shift_d   = tx_data;
          par_d     = calc_parity(8'(tx_data), PARITY);
          bit_cnt_d = 3'd0;
          txd_d     = 1'b0;
          baud_en_d = 1'b1;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (pulse_ok) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (pulse_ok) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              txd_d   = par_q;
              state_d = PAR;
            end else begin
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PAR: begin
        if (pulse_ok) begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (pulse_ok) begin
          if (stop_cnt_q == LAST_STOP) begin
            baud_en_d = 1'b0;
            ready_d   = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      txd        <= 1'b1;
      tx_ready   <= 1'b1;
      baud_en    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd        <= txd_d;
      tx_ready   <= ready_d;
      baud_en    <= baud_en_d;
      tx_busy    <= busy_d;
      tx_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations side by side (8N1, 8O2, 7E1),
// each driven by a bench-side baud pulse model, with a per-frame scoreboard of
// expected line bits popped whenever the framer should move to the next bit.
module tb_uart_tx_frame;

  typedef struct {
    logic b;
    bit   last;
  } exp_bit_t;

  // Frames are written first-transmitted-bit on the left, padded with leading zeros.
  typedef struct {
    int         dut;
    logic [7:0] data;
    int         nbits;
    logic [11:0] frame;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic       baud_pulse [3];
  logic       baud_en [3];
  logic       txd [3];
  logic       tx_busy [3];
  logic       tx_done [3];
  logic       gen_pulse [3];
  logic       stray [3];
  int         gen_cnt [3];

  exp_bit_t   exp_q [3][$];
  bit         done_pending [3];
  int         checkCount;
  int         errorCount;

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .baud_pulse(baud_pulse[0]), .baud_en(baud_en[0]),
    .txd(txd[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .baud_pulse(baud_pulse[1]), .baud_en(baud_en[1]),
    .txd(txd[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2][6:0]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .baud_pulse(baud_pulse[2]), .baud_en(baud_en[2]),
    .txd(txd[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int divOf(input int d);
    return (d == 0) ? 217 : 16;
  endfunction

  // Baud generator model: counts from 0 once enabled, one-clock pulse every divOf clocks.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n || !baud_en[g]) begin
        gen_cnt[g]   <= 0;
        gen_pulse[g] <= 1'b0;
      end else if (gen_cnt[g] == divOf(g) - 1) begin
        gen_cnt[g]   <= 0;
        gen_pulse[g] <= 1'b1;
      end else begin
        gen_cnt[g]   <= gen_cnt[g] + 1;
        gen_pulse[g] <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 3; g++) baud_pulse[g] = gen_pulse[g] | stray[g];
  end

  task automatic checkOutput(input string name, input int d, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s dut%0d: got %0h, want %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: each qualifying pulse ends the current bit; the last
  // bit of a frame must be followed by exactly one tx_done clock.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        exp_q[d].delete();
        done_pending[d] = 1'b0;
      end else begin
        if (done_pending[d]) begin
          checkOutput("done_pulse", d, 32'(tx_done[d]), 1);
          checkOutput("baud_en_after_done", d, 32'(baud_en[d]), 0);
          checkOutput("ready_after_done", d, 32'(tx_ready[d]), 1);
          done_pending[d] = 1'b0;
        end else if (tx_done[d]) begin
          checkOutput("spurious_done", d, 32'(tx_done[d]), 0);
        end
        if (baud_pulse[d] && baud_en[d]) begin
          if (exp_q[d].size() == 0) begin
            checkOutput("bit_without_frame", d, 32'(exp_q[d].size()), 1);
          end else begin
            exp_bit_t e;
            e = exp_q[d].pop_front();
            checkOutput("txd_bit", d, 32'(txd[d]), 32'(e.b));
            if (e.last) done_pending[d] = 1'b1;
          end
        end
      end
    end
  end

  task automatic pushFrame(input int d, input int nbits, input logic [11:0] frame);
    exp_bit_t e;
    for (int i = 0; i < nbits; i++) begin
      e.b    = frame[nbits - 1 - i];
      e.last = (i == nbits - 1);
      exp_q[d].push_back(e);
    end
  endtask

  // Offer one word and wait for the handshake edge; expected bits are queued on acceptance.
  task automatic applyStimulus(input int d, input logic [7:0] data, input int nbits,
                               input logic [11:0] frame, input bit hold_valid);
    int i;
    @(negedge clk); #1;
    tx_data[d]  = data;
    tx_valid[d] = 1'b1;
    i = 0;
    while (!tx_ready[d] && i < 5000) begin
      @(negedge clk); #1;
      i++;
    end
    if (!tx_ready[d]) begin
      checkOutput("handshake_timeout", d, 32'(tx_ready[d]), 1);
      tx_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    pushFrame(d, nbits, frame);
    if (!hold_valid) tx_valid[d] = 1'b0;
    checkOutput("start_bit", d, 32'(txd[d]), 0);
    checkOutput("busy_on_accept", d, 32'(tx_busy[d]), 1);
    checkOutput("baud_en_on_accept", d, 32'(baud_en[d]), 1);
  endtask

  task automatic waitDone(input int d);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      if (exp_q[d].size() == 0 && !done_pending[d]) return;
    end
    checkOutput("frame_timeout", d, 32'(exp_q[d].size()), 0);
  endtask

  task automatic checkIdle(input int d);
    checkOutput("idle_txd", d, 32'(txd[d]), 1);
    checkOutput("idle_ready", d, 32'(tx_ready[d]), 1);
    checkOutput("idle_baud_en", d, 32'(baud_en[d]), 0);
    checkOutput("idle_busy", d, 32'(tx_busy[d]), 0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [9];
    int   viol [3];
    int   cycles, seg_len, nseg, gap;
    logic prev;

    vecs[0] = '{1, 8'h03, 12, 12'b0_11000000_1_11};
    vecs[1] = '{1, 8'hA5, 12, 12'b0_10100101_1_11};
    vecs[2] = '{1, 8'h80, 12, 12'b0_00000001_0_11};
    vecs[3] = '{1, 8'h00, 12, 12'b0_00000000_1_11};
    vecs[4] = '{2, 8'h41, 10, 12'b00_0_1000001_0_1};
    vecs[5] = '{2, 8'h7F, 10, 12'b00_0_1111111_1_1};
    vecs[6] = '{2, 8'h01, 10, 12'b00_0_1000000_1_1};
    vecs[7] = '{2, 8'h00, 10, 12'b00_0_0000000_0_1};
    vecs[8] = '{0, 8'hA5, 10, 12'b00_0_10100101_1};

    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      tx_data[d] = 8'h00; tx_valid[d] = 1'b0; stray[d] = 1'b0; viol[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checkIdle(d);
      checkOutput("reset_done", d, 32'(tx_done[d]), 0);
    end
    rst_n = 1'b1;

    $display("[TB] idle with stray baud pulses");
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) stray[d] = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      for (int d = 0; d < 3; d++)
        if (txd[d] !== 1'b1 || tx_ready[d] !== 1'b1 || baud_en[d] !== 1'b0 || tx_busy[d] !== 1'b0)
          viol[d]++;
    end
    for (int d = 0; d < 3; d++) begin
      stray[d] = 1'b0;
      checkOutput("idle_violations", d, 32'(viol[d]), 0);
    end

    $display("[TB] 8N1 0x55 bit timing");
    applyStimulus(0, 8'h55, 10, 12'b00_0_10101010_1, 1'b0);
    cycles = 0; seg_len = 0; nseg = 0; prev = 1'b0;
    while (cycles < 4000) begin
      @(negedge clk); #1;
      cycles++;
      if (tx_done[0]) begin
        checkOutput("last_stop_len", 0, 32'(seg_len), 217);
        checkOutput("frame_clks_ok", 0, 32'((cycles - 1 >= 2170) && (cycles - 1 <= 2171)), 1);
        checkOutput("segments", 0, 32'(nseg), 9);
        break;
      end
      if (txd[0] === prev) seg_len++;
      else begin
        nseg++;
        if (nseg == 1) checkOutput("start_len_ok", 0, 32'(seg_len == 217 || seg_len == 218), 1);
        else checkOutput("bit_len", 0, 32'(seg_len), 217);
        prev = txd[0];
        seg_len = 1;
      end
    end
    if (cycles >= 4000) checkOutput("timing_timeout", 0, 32'(cycles), 0);
    waitDone(0);
    checkIdle(0);

    $display("[TB] table vectors");
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].dut, vecs[v].data, vecs[v].nbits, vecs[v].frame, 1'b0);
      waitDone(vecs[v].dut);
      checkIdle(vecs[v].dut);
    end

    $display("[TB] back-to-back with valid held");
    applyStimulus(0, 8'hA5, 10, 12'b00_0_10100101_1, 1'b1);
    repeat (500) @(posedge clk);
    #1;
    tx_data[0] = 8'h3C;
    pushFrame(0, 10, 12'b00_0_00111100_1);
    cycles = 0;
    while (!tx_done[0] && cycles < 4000) begin
      @(negedge clk); #1;
      cycles++;
    end
    checkOutput("first_frame_done", 0, 32'(tx_done[0]), 1);
    checkOutput("gap_txd", 0, 32'(txd[0]), 1);
    gap = 0;
    while (tx_ready[0] && gap < 10) begin
      gap++;
      @(negedge clk); #1;
    end
    checkOutput("ready_gap", 0, 32'(gap), 1);
    checkOutput("second_start", 0, 32'(txd[0]), 0);
    checkOutput("second_busy", 0, 32'(tx_busy[0]), 1);
    tx_valid[0] = 1'b0;
    waitDone(0);
    checkIdle(0);

    $display("[TB] reset during data bit 3");
    applyStimulus(0, 8'h00, 10, 12'b00_0_00000000_1, 1'b0);
    cycles = 0;
    while (exp_q[0].size() != 6 && cycles < 4000) begin
      @(negedge clk); #1;
      cycles++;
    end
    checkOutput("reached_bit3", 0, 32'(exp_q[0].size()), 6);
    @(posedge clk); #1;
    checkOutput("bit3_low", 0, 32'(txd[0]), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkIdle(0);
    checkOutput("abort_no_done", 0, 32'(tx_done[0]), 0);
    repeat (5) @(posedge clk);
    applyStimulus(0, 8'hFF, 10, 12'b00_0_11111111_1, 1'b0);
    waitDone(0);
    checkIdle(0);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
